exe_muldiv_unit: RTL

- Iterative multiply/divide unit in the EX stage. It consumes the operands and control that the ID/EX pipeline register launches.
- Drives a stall back toward the hazard logic while an operation runs, then updates the architectural HI/LO registers.
- Implements MIPS MULT, MULTU, DIV, DIVU, MTHI and MTLO. MFHI/MFLO read the hi/lo outputs directly.

---
 rtl/exe_muldiv_unit_if.sv | 28 ++
 rtl/exe_muldiv_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/exe_muldiv_unit_if.sv
// Handshake and data bundle between the ID/EX stage and the iterative multiply/divide unit.
// The master side launches operations and MTHI/MTLO writes; the slave side is the unit itself.
interface exe_muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] srcA;
  logic [WIDTH-1:0] srcB;
  logic             flushE;
  logic             mtWe;
  logic             mtSel;
  logic [WIDTH-1:0] mtData;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, srcA, srcB, flushE, mtWe, mtSel, mtData,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, srcA, srcB, flushE, mtWe, mtSel, mtData,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/exe_muldiv_unit.sv
// Iterative MIPS MULT/MULTU/DIV/DIVU/MTHI/MTLO unit owning the HI/LO registers.
// Define MULDIV_FAST_MULT_EN to complete multiplies in a single cycle instead of WIDTH iterations.
module exe_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  exe_muldiv_unit_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic                 is_div_q, is_div_d;
  logic                 is_signed_q, is_signed_d;
  logic                 sign_a_q, sign_a_d;
  logic                 sign_b_q, sign_b_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]     opb_q, opb_d;
  logic [WIDTH-1:0]     hi_q, hi_d;
  logic [WIDTH-1:0]     lo_q, lo_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                 in_signed;
  logic                 in_sign_a;
  logic                 in_sign_b;
  logic [WIDTH-1:0]     abs_a;
  logic [WIDTH-1:0]     abs_b;

  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  logic [WIDTH:0]       rem_shift;
  logic [WIDTH:0]       rem_sub;
  logic                 q_bit;
  logic [2*WIDTH-1:0]   div_next;
  logic [2*WIDTH-1:0]   step_next;
  logic [2*WIDTH-1:0]   fix_prod;
  logic [WIDTH-1:0]     fix_quot;
  logic [WIDTH-1:0]     fix_rem;

  // Signed ops run on magnitudes; the recorded signs restore the result at the end.
  assign in_signed = ~bus.op[0];
  assign in_sign_a = in_signed & bus.srcA[WIDTH-1];
  assign in_sign_b = in_signed & bus.srcB[WIDTH-1];
  assign abs_a     = in_sign_a ? -bus.srcA : bus.srcA;
  assign abs_b     = in_sign_b ? -bus.srcB : bus.srcB;

`ifdef MULDIV_FAST_MULT_EN
  logic [2*WIDTH-1:0] ext_a;
  logic [2*WIDTH-1:0] ext_b;
  logic [2*WIDTH-1:0] fast_prod;

  // Low 2*WIDTH bits of the extended product are correct for both signed and unsigned.
  assign ext_a     = {{WIDTH{in_sign_a}}, bus.srcA};
  assign ext_b     = {{WIDTH{in_sign_b}}, bus.srcB};
  assign fast_prod = ext_a * ext_b;
`endif

  always_comb begin
    mul_sum   = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next  = {mul_sum, acc_q[WIDTH-1:1]};

    // acc holds {remainder, dividend/quotient}; the remainder gains one dividend bit per step.
    rem_shift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    q_bit     = (rem_shift >= {1'b0, opb_q});
    rem_sub   = q_bit ? (rem_shift - {1'b0, opb_q}) : rem_shift;
    div_next  = {rem_sub[WIDTH-1:0], acc_q[WIDTH-2:0], q_bit};

    step_next = is_div_q ? div_next : mul_next;

    fix_prod  = (is_signed_q && (sign_a_q ^ sign_b_q)) ? -step_next : step_next;
    fix_quot  = (is_signed_q && (sign_a_q ^ sign_b_q)) ? -step_next[WIDTH-1:0]
                                                       : step_next[WIDTH-1:0];
    fix_rem   = (is_signed_q && sign_a_q) ? -step_next[2*WIDTH-1:WIDTH]
                                          : step_next[2*WIDTH-1:WIDTH];
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_div_d    = is_div_q;
    is_signed_d = is_signed_q;
    sign_a_d    = sign_a_q;
    sign_b_d    = sign_b_q;
    acc_d       = acc_q;
    opb_d       = opb_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    busy_d      = busy_q;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          is_div_d    = bus.op[1];
          is_signed_d = in_signed;
          sign_a_d    = in_sign_a;
          sign_b_d    = in_sign_b;
          acc_d       = {{WIDTH{1'b0}}, abs_a};
          opb_d       = abs_b;
          cnt_d       = CW'(WIDTH);
          if (bus.op[1] && (bus.srcB == '0)) begin
            hi_d    = bus.srcA;
            lo_d    = '1;
            done_d  = 1'b1;
            state_d = DONE;
          end
`ifdef MULDIV_FAST_MULT_EN
          else if (!bus.op[1]) begin
            hi_d    = fast_prod[2*WIDTH-1:WIDTH];
            lo_d    = fast_prod[WIDTH-1:0];
            done_d  = 1'b1;
            state_d = DONE;
          end
`endif
          else begin
            busy_d  = 1'b1;
            state_d = RUN;
          end
        end else if (bus.mtWe) begin
          if (bus.mtSel) begin
            hi_d = bus.mtData;
          end else begin
            lo_d = bus.mtData;
          end
        end
      end

      RUN: begin
        if (bus.flushE) begin
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          acc_d = step_next;
          cnt_d = cnt_q - 1'b1;
          if (cnt_q == CW'(1)) begin
            if (is_div_q) begin
              hi_d = fix_rem;
              lo_d = fix_quot;
            end else begin
              hi_d = fix_prod[2*WIDTH-1:WIDTH];
              lo_d = fix_prod[WIDTH-1:0];
            end
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = DONE;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      is_signed_q <= 1'b0;
      sign_a_q    <= 1'b0;
      sign_b_q    <= 1'b0;
      acc_q       <= '0;
      opb_q       <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_div_q    <= is_div_d;
      is_signed_q <= is_signed_d;
      sign_a_q    <= sign_a_d;
      sign_b_q    <= sign_b_d;
      acc_q       <= acc_d;
      opb_q       <= opb_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.hi   = hi_q;
  assign bus.lo   = lo_q;

endmodule
